fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 32, giving the data and address width.
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of instruction queue entries (power of two, 2 or more).
REQ-003 SHALL have parameter RESET_PC, default 0, giving the first fetch address.
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-007 SHALL have port imem_addr, output, N bits: request address.
REQ-008 SHALL have port imem_ack, input, 1 bit: memory completes the held request.
REQ-009 SHALL have port imem_rdata, input, N bits: instruction word, valid with imem_ack.
REQ-010 SHALL have port redirect, input, 1 bit: taken branch or jump, flush.
REQ-011 SHALL have port redirect_pc, input, N bits: new fetch address.
REQ-012 SHALL have port stall, input, 1 bit: the downstream IF/ID register will not load this cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: out_instr and out_pc4 are meaningful.
REQ-014 SHALL have port out_instr, output, N bits: instruction, feeds the IF/ID register data input 1.
REQ-015 SHALL have port out_pc4, output, N bits: instruction address + 4, feeds the IF/ID register data input 2.

Function
REQ-016 SHALL run a three-state FSM:
- IDLE: no request outstanding.
- WAIT: request held.
- DRAIN: held request is stale and its data is discarded.
REQ-017 SHALL go IDLE->WAIT and assert imem_req with imem_addr=fetch_pc when registered (count + outstanding) < DEPTH and redirect=0.
REQ-018 SHALL hold imem_req=1 and imem_addr stable in WAIT and DRAIN until imem_ack=1; ack in the first request cycle is legal.
REQ-019 SHALL, on WAIT with imem_ack=1, enqueue {imem_rdata, fetch_pc+4}, advance fetch_pc by 4 mod 2^N, and go to IDLE.
REQ-020 SHALL pop the head when out_valid=1 and stall=0; pop and enqueue in the same cycle are both honoured.
REQ-021 SHALL, when the queue is not empty, drive out_valid=1 with out_instr and out_pc4 taken from the head entry.
REQ-022 SHALL, on redirect=1:
- empty the queue;
- load fetch_pc with redirect_pc;
- go WAIT->DRAIN, or DRAIN->DRAIN if ack is absent;
- go IDLE if ack is present or no request is outstanding.
REQ-023 SHALL give redirect priority over pop, enqueue and new request issue in the same cycle; the acked word SHALL be discarded.
REQ-024 SHALL go DRAIN->IDLE on imem_ack=1 without enqueueing and without changing fetch_pc.
REQ-025 SHALL never overflow: with the queue full, no request is issued until a pop is registered.
REQ-026 SHALL have a latency of one cycle from imem_ack to out_valid, in the non-bypass build.

Reset
REQ-027 SHALL, on rst, set state=IDLE, fetch_pc=RESET_PC, queue count=0, imem_req=0, out_valid=0, and out_instr=out_pc4=0.
REQ-028 SHALL drop a transaction cut by rst mid-operation, with no DRAIN; the memory is reset by the same rst.
REQ-029 SHALL issue the first request, addr=RESET_PC, in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL provide macro FETCH_BYPASS_EN.
- Defined: when the queue is empty, state=WAIT and imem_ack=1, out_valid=1 and out_instr=imem_rdata and out_pc4=fetch_pc+4 combinationally in the same cycle; if stall=0 the word is consumed and not enqueued.
- Undefined: every word passes through the queue, as in REQ-026.

Structure
REQ-031 SHALL place the FSM state enumeration and the default RESET_PC constant in shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_queue (synchronous FIFO, width 2N, DEPTH entries, push/pop/full/empty/count).

Verification
REQ-033 SHALL check reset: release rst with RESET_PC=0 -> next cycle imem_req=1, imem_addr=0x0, out_valid=0.
REQ-034 SHALL check streaming: ack every request cycle, stall=0, rdata=0xA0,0xA1,0xA2 -> out_instr=0xA0,0xA1,0xA2 with out_pc4=0x4,0x8,0xC.
REQ-035 SHALL check backpressure: stall=1 for 5 cycles, DEPTH=2 -> after two acks imem_req=0 and out_instr holds 0xA0; stall=0 -> resume at addr 0x8.
REQ-036 SHALL check redirect while a request is pending: request at 0x10 pending, redirect_pc=0x100, ack 2 cycles later -> data discarded, next imem_addr=0x100, out_valid=0 until its ack.
REQ-037 SHALL check redirect and ack in the same cycle: redirect_pc=0x200 -> acked word discarded, queue empty, next request addr=0x200.
REQ-038 SHALL check the bypass build: FETCH_BYPASS_EN, empty queue, ack rdata=0x55 -> out_valid=1, out_instr=0x55 in the ack cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [63:0] FETCH_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc4} pairs; flush empties it in one cycle.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, DEPTH-entry queue, redirect flush.
// Define FETCH_BYPASS_EN to forward an acked word straight to the output when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          N        = 32,
  parameter int          DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = N'(FETCH_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  input  logic         stall,
  output logic         out_valid,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   addr_q, addr_d;
  logic [N-1:0]   pc4;
  logic           push, pop, full, empty, byp_valid, byp_take;
  logic [2*N-1:0] head;
  logic [CW-1:0]  count;

  assign pc4 = pc_q + N'(4);

  fetch_queue #(.W(2*N), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .din_i   ({imem_rdata, pc4}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    byp_valid = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp_valid = empty && (state_q == WAIT) && imem_ack;
`endif
    byp_take  = byp_valid && !stall;
    out_valid = !empty || byp_valid;
    out_instr = '0;
    out_pc4   = '0;
    if (!empty) begin
      out_instr = head[2*N-1:N];
      out_pc4   = head[N-1:0];
    end else if (byp_valid) begin
      out_instr = imem_rdata;
      out_pc4   = pc4;
    end
  end

  assign pop = !empty && !stall && !redirect;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    push      = 1'b0;
    imem_req  = (state_q != IDLE);
    imem_addr = addr_q;
    case (state_q)
      IDLE: begin
        // Only IDLE issues, so outstanding is zero and the room check is count alone.
        if (!redirect && (count < CW'(DEPTH))) begin
          state_d = WAIT;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          state_d = IDLE;
          pc_d    = pc4;
          push    = !byp_take && (!full || pop);
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic vs a transaction model.
module tb_fetch_unit;

  localparam int N = 32;
  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_ack = 1'b0, redirect = 1'b0, stall = 1'b0;
  logic [N-1:0] imem_rdata = '0, redirect_pc = '0;
  logic         imem_req, out_valid;
  logic [N-1:0] imem_addr, out_instr, out_pc4;

  always #5 clk = ~clk;

  fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc4     (out_pc4)
  );

  int vectors = 0;
  int miss = 0;

  // Model: queue of fetched words, current fetch pc, and one pending request record.
  logic [2*N-1:0] mq[$];
  logic [N-1:0]   m_pc, m_addr;
  bit             m_pend, m_stale;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = '0; m_addr = '0; m_pend = 0; m_stale = 0;
  endtask

  task automatic check_model();
    logic [2*N-1:0] e;
    bit v;
    v = 0; e = '0;
    if (mq.size() > 0) begin
      v = 1; e = mq[0];
    end else if (BYP && m_pend && !m_stale && imem_ack) begin
      v = 1; e = {imem_rdata, m_addr + 32'd4};
    end
    chk("imem_req", imem_req, m_pend);
    if (m_pend) chk("imem_addr", imem_addr, m_addr);
    chk("out_valid", out_valid, v);
    chk("out_instr", out_instr, e[2*N-1:N]);
    chk("out_pc4", out_pc4, e[N-1:0]);
  endtask

  task automatic model_update();
    int  size0;
    bit  byp;
    size0 = mq.size();
    byp = BYP && size0 == 0 && m_pend && !m_stale && imem_ack;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc;
      if (m_pend && !imem_ack) m_stale = 1;
      else m_pend = 0;
    end else begin
      if (size0 > 0 && !stall) void'(mq.pop_front());
      if (m_pend && imem_ack) begin
        if (!m_stale) begin
          if (!(byp && !stall)) mq.push_back({imem_rdata, m_addr + 32'd4});
          m_pc = m_addr + 32'd4;
        end
        m_pend = 0;
      end else if (!m_pend && size0 < DEPTH) begin
        m_pend = 1; m_addr = m_pc; m_stale = 0;
      end
    end
  endtask

  task automatic step();
    #1;
    if (rst) model_reset();
    check_model();
    if (!rst) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; imem_ack = 0; redirect = 0; stall = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic wait_req(input string tag);
    imem_ack = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_req) break;
      step();
    end
    chk(tag, imem_req, 1'b1);
  endtask

  logic [N-1:0] got_i[3], got_p[3];
  int k, pops;

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Reset release: request at RESET_PC on the next cycle.
    do_reset();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    step();
    #1;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", out_valid, 1'b0);

    // Streaming.
    do_reset();
    k = 0; pops = 0;
    foreach (got_i[i]) begin got_i[i] = '0; got_p[i] = '0; end
    for (int c = 0; c < 40 && pops < 3; c++) begin
      imem_ack = m_pend;
      imem_rdata = 32'hA0 + k;
      #1;
      if (out_valid) begin
        got_i[pops] = out_instr; got_p[pops] = out_pc4; pops++;
      end
      if (imem_ack) k++;
      step();
    end
    imem_ack = 0;
    chk("stream_count", pops, 3);
    for (int i = 0; i < 3; i++) begin
      chk("stream_instr", got_i[i], 32'hA0 + i);
      chk("stream_pc4", got_p[i], 32'h4 * (i + 1));
    end

    // Backpressure.
    do_reset();
    k = 0; stall = 1;
    for (int c = 0; c < 5; c++) begin
      imem_ack = m_pend;
      imem_rdata = 32'hA0 + k;
      if (imem_ack) k++;
      step();
    end
    imem_ack = 0;
    #1;
    chk("bp_req", imem_req, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_instr", out_instr, 32'hA0);
    stall = 0;
    step();
    wait_req("bp_resume_req");
    chk("bp_resume_addr", imem_addr, 32'h8);

    // Redirect with a request pending at 0x10.
    do_reset();
    k = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (m_pend && m_addr == 32'h10) break;
      imem_ack = m_pend;
      imem_rdata = 32'h300 + k; k++;
      step();
      imem_ack = 0;
    end
    imem_ack = 0;
    chk("rp_addr", imem_addr, 32'h10);
    redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    #1;
    chk("rp_hold_addr", imem_addr, 32'h10);
    chk("rp_hold_req", imem_req, 1'b1);
    step();
    imem_ack = 1; imem_rdata = 32'hDEAD;
    step();
    imem_ack = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("rp_valid_low", out_valid, 1'b0);
      if (imem_req) break;
      step();
    end
    chk("rp_req", imem_req, 1'b1);
    chk("rp_newaddr", imem_addr, 32'h100);
    imem_ack = 1; imem_rdata = 32'h77;
    step();
    imem_ack = 0;
    #1;
    chk("rp_out_valid", out_valid, 1'b1);
    chk("rp_out_instr", out_instr, 32'h77);
    chk("rp_out_pc4", out_pc4, 32'h104);

    // Redirect and ack in the same cycle.
    do_reset();
    wait_req("sc_req");
    redirect = 1; redirect_pc = 32'h200; imem_ack = 1; imem_rdata = 32'h99;
    step();
    redirect = 0; imem_ack = 0;
    #1;
    chk("sc_valid", out_valid, 1'b0);
    wait_req("sc_req2");
    chk("sc_addr", imem_addr, 32'h200);

`ifdef FETCH_BYPASS_EN
    do_reset();
    wait_req("byp_req");
    stall = 1; imem_ack = 1; imem_rdata = 32'h55;
    #1;
    chk("byp_valid", out_valid, 1'b1);
    chk("byp_instr", out_instr, 32'h55);
    chk("byp_pc4", out_pc4, 32'h4);
    step();
    imem_ack = 0; stall = 0;
`endif

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 9) < 3);
      imem_ack    = m_pend && ($urandom_range(0, 1) == 1);
      imem_rdata  = $urandom;
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom & ~32'd3;
      rst         = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; imem_ack = 0; redirect = 0; stall = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
